msrh_l1d_miss_queue: RTL and testbench

- Parametrised L1D miss queue; successor to the fixed-port L1D load requester.
- Accepts line-miss requests from REQ_PORTS LSU pipes per cycle and merges same-line requests.
- Issues one L2 read per cycle with valid/ready backpressure and round-robin entry selection.
- Accepts out-of-order L2 responses by tag, forwards refill data to L1D, and broadcasts resolve to the LDQ.

---
 rtl/msrh_lsu_pkg.sv | 19 +
 rtl/msrh_l1d_miss_entry.sv | 44 ++++
 rtl/msrh_l1d_miss_queue.sv | 205 ++++++++++++++++++++
 tb/tb_msrh_l1d_miss_queue.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrh_lsu_pkg.sv
// Shared LSU types for the L1D miss queue.
// Entry state, entry record and the L1D source tag bit.
package msrh_lsu_pkg;

  localparam int MISS_PADDR_MAX = 64;
  localparam logic L2_UPPER_TAG_L1D = 1'b0;

  typedef enum logic [1:0] {
    MISS_FREE,
    MISS_WAIT_SEND,
    MISS_WAIT_RESP
  } miss_state_t;

  typedef struct packed {
    miss_state_t                state;
    logic [MISS_PADDR_MAX-1:0]  paddr;
  } miss_entry_t;

endpackage

// File: rtl/msrh_l1d_miss_entry.sv
// One miss-queue slot: lifecycle FSM plus line address.
// Address is zero-extended into the shared entry record.
import msrh_lsu_pkg::*;

module msrh_l1d_miss_entry #(
  parameter int PADDR_W = 56
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic [PADDR_W-1:0] i_paddr,
  input  logic               i_sent,
  input  logic               i_resp_hit,
  output miss_entry_t        o_entry
);

  miss_state_t        r_state;
  miss_state_t        w_state_nxt;
  logic [PADDR_W-1:0] r_paddr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= MISS_FREE;
      r_paddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_load) r_paddr <= i_paddr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MISS_FREE:      if (i_load)     w_state_nxt = MISS_WAIT_SEND;
      MISS_WAIT_SEND: if (i_sent)     w_state_nxt = MISS_WAIT_RESP;
      MISS_WAIT_RESP: if (i_resp_hit) w_state_nxt = MISS_FREE;
      default:                        w_state_nxt = MISS_FREE;
    endcase
  end

  assign o_entry.state = r_state;
  assign o_entry.paddr = MISS_PADDR_MAX'(r_paddr);

endmodule

// File: rtl/msrh_l1d_miss_queue.sv
// L1D miss queue: merge/allocate LSU misses, RR-issue L2 reads,
// accept tagged out-of-order refills and pulse resolve to the LDQ.
import msrh_lsu_pkg::*;

module msrh_l1d_miss_queue #(
  parameter int   REQ_PORTS  = 2,
  parameter int   ENTRIES    = 8,
  parameter int   PADDR_W    = 56,
  parameter int   LINE_OFS_W = 6,
  parameter int   LINE_W     = 512,
  parameter int   TAG_W      = 8,
  parameter logic UPPER_TAG  = L2_UPPER_TAG_L1D
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [REQ_PORTS-1:0]           i_req_valid,
  input  logic [REQ_PORTS*PADDR_W-1:0]   i_req_paddr,
  output logic [REQ_PORTS-1:0]           o_req_accept,
  output logic [REQ_PORTS-1:0]           o_req_conflict,
  output logic [REQ_PORTS-1:0]           o_req_full,
  output logic [REQ_PORTS*ENTRIES-1:0]   o_req_index_oh,
  output logic                           o_l2_req_valid,
  input  logic                           i_l2_req_ready,
  output logic [PADDR_W-1:0]             o_l2_req_addr,
  output logic [TAG_W-1:0]               o_l2_req_tag,
  input  logic                           i_l2_resp_valid,
  input  logic [TAG_W-1:0]               i_l2_resp_tag,
  input  logic [LINE_W-1:0]              i_l2_resp_data,
  output logic                           o_refill_valid,
  output logic [PADDR_W-1:0]             o_refill_paddr,
  output logic [LINE_W-1:0]              o_refill_data,
  output logic                           o_resolve_valid,
  output logic [ENTRIES-1:0]             o_resolve_index_oh,
  output logic                           o_busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int LN_W  = PADDR_W - LINE_OFS_W;

  function automatic logic [PADDR_W-1:0] align(input logic [LN_W-1:0] ln);
    return {ln, {LINE_OFS_W{1'b0}}};
  endfunction

  miss_entry_t                      w_entry [ENTRIES];
  logic [ENTRIES-1:0]               w_free;
  logic [ENTRIES-1:0]               w_send;
  logic [ENTRIES-1:0]               w_load;
  logic [ENTRIES-1:0]               w_sent;
  logic [ENTRIES-1:0]               w_hit;
  logic [ENTRIES-1:0][PADDR_W-1:0]  w_load_paddr;
  logic [ENTRIES-1:0][LN_W-1:0]     w_ent_line;
  logic [REQ_PORTS-1:0][LN_W-1:0]   w_req_line;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    logic w_unused_pad;
    msrh_l1d_miss_entry #(.PADDR_W(PADDR_W)) u_entry (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load     (w_load[e]),
      .i_paddr    (w_load_paddr[e]),
      .i_sent     (w_sent[e]),
      .i_resp_hit (w_hit[e]),
      .o_entry    (w_entry[e])
    );
    assign w_free[e]     = w_entry[e].state == MISS_FREE;
    assign w_send[e]     = w_entry[e].state == MISS_WAIT_SEND;
    assign w_ent_line[e] = w_entry[e].paddr[PADDR_W-1:LINE_OFS_W];
    assign w_unused_pad  = ^w_entry[e].paddr;
  end

  for (genvar p = 0; p < REQ_PORTS; p++) begin : g_line
    assign w_req_line[p] = i_req_paddr[p*PADDR_W+LINE_OFS_W +: LN_W];
  end

  // Allocation and merge; freed-this-cycle entries still read as busy
  logic [ENTRIES-1:0]                w_avail;
  logic [ENTRIES-1:0]                w_pick;
  logic [REQ_PORTS-1:0]              w_acc;
  logic [REQ_PORTS-1:0]              w_conf;
  logic [REQ_PORTS-1:0]              w_full;
  logic [REQ_PORTS-1:0][ENTRIES-1:0] w_oh;

  always_comb begin
    w_avail      = w_free;
    w_pick       = '0;
    w_load       = '0;
    w_load_paddr = '0;
    w_acc        = '0;
    w_conf       = '0;
    w_full       = '0;
    w_oh         = '0;
    for (int p = 0; p < REQ_PORTS; p++) begin
      if (i_req_valid[p]) begin
        for (int e = 0; e < ENTRIES; e++) begin
          if (!w_free[e] && w_ent_line[e] == w_req_line[p]) begin
            w_conf[p]    = 1'b1;
            w_oh[p][e]   = 1'b1;
          end
        end
        for (int q = 0; q < p; q++) begin
          if (!w_conf[p] && w_acc[q] &&
              w_req_line[q] == w_req_line[p]) begin
            w_conf[p] = 1'b1;
            w_oh[p]   = w_oh[q];
          end
        end
        if (!w_conf[p]) begin
          w_pick = w_avail & (~w_avail + ENTRIES'(1));
          if (|w_pick) begin
            w_acc[p] = 1'b1;
            w_oh[p]  = w_pick;
            w_avail  = w_avail & ~w_pick;
            w_load   = w_load | w_pick;
            for (int e = 0; e < ENTRIES; e++) begin
              if (w_pick[e]) w_load_paddr[e] = align(w_req_line[p]);
            end
          end else begin
            w_full[p] = 1'b1;
          end
        end
      end
    end
  end

  assign o_req_accept   = w_acc;
  assign o_req_conflict = w_conf;
  assign o_req_full     = w_full;
  assign o_req_index_oh = w_oh;

  // RR issue; a stalled offer is locked so addr/tag cannot move
  logic [IDX_W-1:0] r_rr;
  logic [IDX_W-1:0] r_lock_idx;
  logic             r_lock;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_cand;
  logic             w_any;

  always_comb begin
    w_any  = 1'b0;
    w_sel  = r_rr;
    w_cand = r_rr;
    for (int k = 0; k < ENTRIES; k++) begin
      w_cand = r_rr + IDX_W'(k);
      if (!w_any && w_send[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
    if (r_lock) begin
      w_any = 1'b1;
      w_sel = r_lock_idx;
    end
  end

  always_comb begin
    o_l2_req_tag = '0;
    if (w_any) begin
      o_l2_req_tag[TAG_W-1]   = UPPER_TAG;
      o_l2_req_tag[IDX_W-1:0] = w_sel;
    end
  end

  assign o_l2_req_valid = w_any;
  assign o_l2_req_addr  = w_any ? align(w_ent_line[w_sel]) : '0;
  assign w_sent = (w_any && i_l2_req_ready) ? (ENTRIES'(1) << w_sel) : '0;

  logic [IDX_W-1:0] w_resp_idx;
  logic             w_resp_ok;
  logic             w_unused;

  assign w_resp_idx = i_l2_resp_tag[IDX_W-1:0];
  assign w_resp_ok  = i_l2_resp_valid &&
                      (i_l2_resp_tag[TAG_W-1] == UPPER_TAG) &&
                      (w_entry[w_resp_idx].state == MISS_WAIT_RESP);
  assign w_hit      = w_resp_ok ? (ENTRIES'(1) << w_resp_idx) : '0;
  assign w_unused   = ^{i_l2_resp_tag, i_req_paddr};

  assign o_refill_valid = w_resp_ok;
  assign o_refill_paddr = w_resp_ok ? align(w_ent_line[w_resp_idx]) : '0;
  assign o_refill_data  = w_resp_ok ? i_l2_resp_data : '0;

  logic               r_res_v;
  logic [ENTRIES-1:0] r_res_oh;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_res_v    <= 1'b0;
      r_res_oh   <= '0;
    end else begin
      if (w_any && i_l2_req_ready) r_rr <= w_sel + IDX_W'(1);
      r_lock <= w_any && !i_l2_req_ready;
      if (w_any) r_lock_idx <= w_sel;
      r_res_v  <= w_resp_ok;
      r_res_oh <= w_hit;
    end
  end

  assign o_resolve_valid    = r_res_v;
  assign o_resolve_index_oh = r_res_oh;
  assign o_busy             = ~&w_free;

endmodule

// File: tb/tb_msrh_l1d_miss_queue.sv
// Self-checking bench for msrh_l1d_miss_queue.
// Directed scenarios then random traffic against a line-level model.
module tb_msrh_l1d_miss_queue;

  localparam int RP = 2;
  localparam int E  = 8;
  localparam int PW = 56;
  localparam int LW = 512;
  localparam int TW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [RP-1:0]     req_valid;
  logic [RP*PW-1:0]  req_paddr;
  logic [RP-1:0]     req_accept, req_conflict, req_full;
  logic [RP*E-1:0]   req_index_oh;
  logic              l2_valid, l2_ready;
  logic [PW-1:0]     l2_addr;
  logic [TW-1:0]     l2_tag;
  logic              resp_valid;
  logic [TW-1:0]     resp_tag;
  logic [LW-1:0]     resp_data;
  logic              refill_valid;
  logic [PW-1:0]     refill_paddr;
  logic [LW-1:0]     refill_data;
  logic              resolve_valid;
  logic [E-1:0]      resolve_oh;
  logic              busy;

  always #5 clk = ~clk;

  msrh_l1d_miss_queue dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_req_valid        (req_valid),
    .i_req_paddr        (req_paddr),
    .o_req_accept       (req_accept),
    .o_req_conflict     (req_conflict),
    .o_req_full         (req_full),
    .o_req_index_oh     (req_index_oh),
    .o_l2_req_valid     (l2_valid),
    .i_l2_req_ready     (l2_ready),
    .o_l2_req_addr      (l2_addr),
    .o_l2_req_tag       (l2_tag),
    .i_l2_resp_valid    (resp_valid),
    .i_l2_resp_tag      (resp_tag),
    .i_l2_resp_data     (resp_data),
    .o_refill_valid     (refill_valid),
    .o_refill_paddr     (refill_paddr),
    .o_refill_data      (refill_data),
    .o_resolve_valid    (resolve_valid),
    .o_resolve_index_oh (resolve_oh),
    .o_busy             (busy)
  );

  int errors = 0;
  int checks = 0;

  // Model: 0 = free, 1 = waiting to send, 2 = waiting for response
  int          m_st [E];
  logic [PW-1:0] m_addr [E];
  int          m_rr;
  bit          m_lock;
  int          m_lidx;
  bit          m_res_v;
  logic [E-1:0] m_res_oh;
  logic [PW-1:0] pool [12];

  task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < E; e++) begin
      m_st[e] = 0;
      m_addr[e] = '0;
    end
    m_rr = 0; m_lock = 0; m_lidx = 0;
    m_res_v = 0; m_res_oh = '0;
  endtask

  task automatic idle();
    req_valid = '0; req_paddr = '0; l2_ready = 1'b0;
    resp_valid = 1'b0; resp_tag = '0; resp_data = '0;
  endtask

  task automatic req(int p, logic [PW-1:0] a);
    req_valid[p] = 1'b1;
    req_paddr[p*PW +: PW] = a;
  endtask

  task automatic resp(int tag);
    resp_valid = 1'b1;
    resp_tag = TW'(tag);
    resp_data = {16{$urandom}};
  endtask

  // One cycle: predict, compare at negedge, advance model at posedge
  task automatic step();
    int eidx [RP];
    bit acc [RP], conf [RP], full [RP];
    bit taken [E];
    bit lv, hit;
    int sel, ridx;
    logic [PW-1:0] ln;
    logic [E-1:0] oh;
    for (int e = 0; e < E; e++) taken[e] = 0;
    for (int p = 0; p < RP; p++) begin
      acc[p] = 0; conf[p] = 0; full[p] = 0; eidx[p] = -1;
      if (req_valid[p]) begin
        ln = req_paddr[p*PW +: PW] >> 6;
        for (int e = 0; e < E; e++)
          if (m_st[e] != 0 && (m_addr[e] >> 6) == ln) begin
            conf[p] = 1; eidx[p] = e;
          end
        if (!conf[p])
          for (int q = 0; q < p; q++)
            if (acc[q] && (req_paddr[q*PW +: PW] >> 6) == ln) begin
              conf[p] = 1; eidx[p] = eidx[q];
            end
        if (!conf[p]) begin
          for (int e = 0; e < E; e++)
            if (eidx[p] < 0 && m_st[e] == 0 && !taken[e]) begin
              eidx[p] = e; taken[e] = 1;
            end
          if (eidx[p] >= 0) acc[p] = 1;
          else full[p] = 1;
        end
      end
    end
    lv = 0; sel = 0;
    if (m_lock) begin
      lv = 1; sel = m_lidx;
    end else begin
      for (int k = 0; k < E; k++)
        if (!lv && m_st[(m_rr + k) % E] == 1) begin
          lv = 1; sel = (m_rr + k) % E;
        end
    end
    ridx = int'(resp_tag) % E;
    hit = resp_valid && !resp_tag[TW-1] && m_st[ridx] == 2;

    @(negedge clk);
    for (int p = 0; p < RP; p++) begin
      oh = '0;
      if (eidx[p] >= 0) oh[eidx[p]] = 1'b1;
      chk($sformatf("accept%0d", p), req_accept[p], acc[p]);
      chk($sformatf("conflict%0d", p), req_conflict[p], conf[p]);
      chk($sformatf("full%0d", p), req_full[p], full[p]);
      chk($sformatf("index_oh%0d", p), req_index_oh[p*E +: E], oh);
    end
    chk("l2_valid", l2_valid, lv);
    if (lv) begin
      chk("l2_addr", l2_addr, m_addr[sel]);
      chk("l2_tag", l2_tag, TW'(sel));
    end
    chk("refill_valid", refill_valid, hit);
    if (hit) begin
      chk("refill_paddr", refill_paddr, m_addr[ridx]);
      chk("refill_data", refill_data, resp_data);
    end
    chk("resolve_valid", resolve_valid, m_res_v);
    chk("resolve_oh", resolve_oh, m_res_oh);
    lv = lv; // keep handshake decision below
    begin
      bit any = 0;
      for (int e = 0; e < E; e++) if (m_st[e] != 0) any = 1;
      chk("busy", busy, any);
    end

    @(posedge clk);
    m_res_v = hit;
    m_res_oh = '0;
    if (hit) begin
      m_res_oh[ridx] = 1'b1;
      m_st[ridx] = 0;
    end
    if (lv) begin
      if (l2_ready) begin
        m_st[sel] = 2; m_rr = (sel + 1) % E; m_lock = 0;
      end else begin
        m_lock = 1; m_lidx = sel;
      end
    end
    for (int p = 0; p < RP; p++)
      if (acc[p]) begin
        m_st[eidx[p]] = 1;
        m_addr[eidx[p]] = req_paddr[p*PW +: PW] & ~PW'(63);
      end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_l2_valid", l2_valid, 1'b0);
    chk("rst_resolve", resolve_valid, 1'b0);
    chk("rst_refill", refill_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pick_resp();
    int q [$];
    for (int e = 0; e < E; e++) if (m_st[e] == 2) q.push_back(e);
    if (q.size() > 0) resp(q[$urandom_range(q.size() - 1)]);
  endtask

  task automatic drain();
    bit any = 1;
    for (int n = 0; n < 60 && any; n++) begin
      idle(); l2_ready = 1'b1; pick_resp();
      step();
      any = 0;
      for (int e = 0; e < E; e++) if (m_st[e] != 0) any = 1;
    end
    idle();
    chk("drain_timeout", any, 1'b0);
  endtask

  initial begin
    logic [63:0] r64;
    idle();
    model_reset();
    for (int i = 0; i < 12; i++) begin
      r64 = {$urandom, $urandom};
      pool[i] = r64[PW-1:0];
    end
    #1;
    do_reset();

    // Two distinct lines, then in-order issue of entry0/entry1
    idle(); req(0, 56'h1000_0040); req(1, 56'h2000_0000); l2_ready = 1; step();
    idle(); l2_ready = 1; step();
    idle(); l2_ready = 1; step();
    idle(); resp(0); step();
    idle(); resp(1); step();
    drain();

    // Same-line merge across ports
    idle(); req(0, 56'h1000_0000); req(1, 56'h1000_0038); l2_ready = 1; step();
    idle(); l2_ready = 1; step();
    idle(); l2_ready = 1; step();
    drain();

    // Fill, overflow, free entry3, reuse
    for (int i = 0; i < 4; i++) begin
      idle(); l2_ready = 1;
      req(0, 56'h3000_0000 + 56'(i * 128));
      req(1, 56'h3000_0040 + 56'(i * 128));
      step();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); l2_ready = 1; step();
    end
    idle(); req(0, 56'h4000_0000); step();
    idle(); resp(3); step();
    idle(); req(0, 56'h4000_0000); step();
    drain();

    // Backpressure: three pending, ready low for 5 cycles
    idle(); req(0, 56'h5000_0000); req(1, 56'h5000_0040); step();
    idle(); req(0, 56'h5000_0080); step();
    for (int i = 0; i < 4; i++) begin
      idle(); step();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); l2_ready = 1; step();
    end
    // Out-of-order responses
    idle(); resp(2); step();
    idle(); resp(0); step();
    idle(); resp(1); step();
    idle(); step();

    // Dropped responses: free entry, foreign MSB
    idle(); req(0, 56'h6000_0000); l2_ready = 1; step();
    idle(); l2_ready = 1; step();
    idle(); resp(5); step();
    idle(); resp(8'h80); step();
    drain();

    // Reset with 4 outstanding, then a stale response
    idle(); req(0, 56'h7000_0000); req(1, 56'h7000_0040); step();
    idle(); req(0, 56'h7000_0080); req(1, 56'h7000_00c0); step();
    for (int i = 0; i < 5; i++) begin
      idle(); l2_ready = 1; step();
    end
    do_reset();
    idle(); resp(1); step();
    idle(); step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int p = 0; p < RP; p++)
        if ($urandom_range(2) != 0)
          req(p, pool[$urandom_range(11)] ^ PW'($urandom_range(63)));
      l2_ready = $urandom_range(3) != 0;
      if ($urandom_range(9) < 6) pick_resp();
      else if ($urandom_range(3) == 0)
        resp(int'($urandom_range(255)));
      if ($urandom_range(150) == 0) do_reset();
      else step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
